ddr3_test_sequencer: RTL and testbench
======================================

Name: ddr3_test_sequencer

Overview:
- Drives the DDR3 MIG user (app) interface to run a memory test: it writes an address-derived pattern over a region, reads it back and compares each beat.
- Sits between the MIG `ui_clk` domain and the top level. It supplies `app_*` commands and data and reports busy/done/error/pass status to the LEDs and to `tg_compare_error`.
- Runs once per start, or loops continuously with a per-pass pattern change.

Parameters:
- ADDR_W, 28, MIG app address width
- DATA_W, 128, MIG app data width (BL8 x 16-bit)
- START_ADDR, 28'h0000000, first test address; a multiple of ADDR_STEP
- END_ADDR, 28'h0010000, exclusive end address; a multiple of ADDR_STEP and greater than START_ADDR
- ADDR_STEP, 8, address increment per 128-bit beat
- MAX_OUTSTANDING, 16, maximum read commands issued but not yet returned

Ports:
- i_clk  in  1  MIG ui_clk
- i_rst  in  1  async active-high reset (ui_clk_sync_rst)
- i_calib_done  in  1  MIG init_calib_complete
- i_start  in  1  one-cycle start pulse
- i_continuous  in  1  loop passes when 1; sampled at each end of pass
- o_app_addr  out  ADDR_W  app_addr
- o_app_cmd  out  3  app_cmd: 3'b000 write, 3'b001 read
- o_app_en  out  1  app_en
- i_app_rdy  in  1  app_rdy
- o_app_wdf_data  out  DATA_W  app_wdf_data
- o_app_wdf_wren  out  1  app_wdf_wren
- o_app_wdf_end  out  1  app_wdf_end; always equal to o_app_wdf_wren
- i_app_wdf_rdy  in  1  app_wdf_rdy
- i_app_rd_data  in  DATA_W  app_rd_data
- i_app_rd_data_valid  in  1  app_rd_data_valid
- o_busy  out  1  test in progress
- o_done  out  1  single-shot test finished
- o_error  out  1  sticky compare error
- o_err_addr  out  ADDR_W  address of the first mismatching beat
- o_pass_cnt  out  16  completed passes; wraps at 16'hFFFF

Behaviour:
- Clock and reset: one clock, `i_clk`. Reset `i_rst` is asynchronous and active-high.
  - All state is cleared by reset: state returns to IDLE and every output goes to 0.
  - Reset asserted mid-operation aborts immediately. No recovery of in-flight commands is attempted.
- Pattern: `pat(a,p) = {8{a[18:3] ^ p[15:0]}}`, where `a` is the beat address and `p` is `o_pass_cnt`. Beat count N = (END_ADDR - START_ADDR) / ADDR_STEP.
- States: IDLE, WAIT_CALIB, WRITE, READ, DRAIN, DONE.
- IDLE / DONE:
  - `i_start` moves to WAIT_CALIB and clears `o_done`, `o_error`, `o_err_addr` and `o_pass_cnt`.
  - `i_start` is ignored in every other state.
- WAIT_CALIB: when `i_calib_done` = 1, load wr_addr = rd_addr = chk_addr = START_ADDR and go to WRITE.
- WRITE:
  - `o_app_en` = 1 with cmd = write and addr = wr_addr, held until `i_app_rdy` = 1.
  - `o_app_wdf_wren` = `o_app_wdf_end` = 1 with data = `pat(wr_addr, pass)`, held until `i_app_wdf_rdy` = 1.
  - Command and data handshakes retire independently. Each sets its own done flag, and each strobe drops in the cycle after its handshake.
  - When both flags are set (including the same cycle), the beat retires: wr_addr += ADDR_STEP and both flags clear.
  - After the last beat retires, go to READ. The first read command appears the next cycle.
- READ:
  - `o_app_en` = 1 with cmd = read and addr = rd_addr while outstanding < MAX_OUTSTANDING; `o_app_en` = 0 otherwise.
  - On `i_app_rdy`, rd_addr += ADDR_STEP and outstanding += 1.
  - After the last read is accepted, go to DRAIN.
- Outstanding counter:
  - Incremented on each accepted read command.
  - Decremented on each `i_app_rd_data_valid`.
  - A simultaneous accept and return leaves it unchanged.
- Compare: active in READ and DRAIN.
  - Each `i_app_rd_data_valid` compares `i_app_rd_data` with `pat(chk_addr, pass)`, then chk_addr += ADDR_STEP.
  - On mismatch: `o_error` <= 1 (sticky). If `o_error` was 0, `o_err_addr` <= chk_addr; later errors do not overwrite it.
- Spurious return: `i_app_rd_data_valid` with outstanding = 0 sets `o_error` and sets `o_err_addr` to all ones if no error is recorded yet.
- DRAIN: when outstanding = 0 and all N beats are checked:
  - `o_pass_cnt` += 1.
  - If `i_continuous` = 1: reload the addresses and go to WRITE (new pattern).
  - Otherwise go to DONE.
- Status outputs:
  - `o_busy` = 1 in WAIT_CALIB, WRITE, READ and DRAIN.
  - `o_done` = 1 only in DONE.
- Calibration loss: `i_calib_done` falling in WRITE, READ or DRAIN aborts to IDLE.
  - `o_app_en` and `o_app_wdf_wren` drop the next cycle.
  - `o_error` and `o_pass_cnt` are retained; `o_done` stays 0.
- Continuous mode: a test stops only on reset or calibration loss. An error does not stop a pass.

Decomposition:
- Package `ddr3_test_pkg` holds:
  - the state enum;
  - the CMD_WRITE and CMD_READ constants;
  - the `pat()` function, so the bench uses the identical pattern.
- One sub-module, `ddr3_test_checker`: outstanding counter, compare, chk_addr, error capture.
- The sequencer FSM and command/data issue stay in the top module.

Test Plan:
- Directed scenarios: unless stated otherwise, each uses START = 0 and END = 0x40 (N = 8) with a MIG behavioural model.
- Clean single pass: calib = 1, `i_start` -> 8 writes at 0x00..0x38, then 8 reads; `o_done` = 1, `o_error` = 0, `o_pass_cnt` = 1; beat 0x08 data = {8{16'h0001}}.
- Handshake independence: `i_app_wdf_rdy` lags `i_app_rdy` by 3 cycles, and separately leads it -> each beat retires only when both are done; addresses are not skipped or repeated.
- Injected error: the model flips bit 5 of the beat at 0x20 -> `o_error` = 1, `o_err_addr` = 0x20, run completes with `o_done` = 1.
  - Also flipping 0x30 leaves `o_err_addr` = 0x20.
- Outstanding limit: MAX_OUTSTANDING = 4, read latency 20 cycles -> never more than 4 reads in flight; all 8 beats are checked.
- Continuous mode: `i_continuous` = 1 for 3 passes -> `o_pass_cnt` = 3; pass-2 pattern at 0x08 = {8{16'h0003}}, no error.
- Aborts:
  - `i_calib_done` drops mid-READ -> IDLE next cycle, `o_app_en` = 0, `o_busy` = 0.
  - `i_rst` mid-WRITE -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ddr3_test_pkg.sv
// Shared types and helpers for the DDR3 memory test sequencer.
package ddr3_test_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CALIB,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // Address-derived test pattern: beat-index bits of the address XOR the
  // pass number, replicated across all eight 16-bit lanes of the beat.
  function automatic logic [127:0] pat(input logic [31:0] a, input logic [15:0] p);
    return {8{a[18:3] ^ p}};
  endfunction

endpackage

// File: rtl/ddr3_test_checker.sv
// Read-side checker: tracks reads in flight, compares returned beats against
// the expected pattern and captures the first failing address.
module ddr3_test_checker
  import ddr3_test_pkg::*;
#(
  parameter int                ADDR_W     = 28,
  parameter int                DATA_W     = 128,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = 28'h0010000,
  parameter logic [ADDR_W-1:0] ADDR_STEP  = 8,
  parameter int                CNT_W      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              reload,
  input  logic              active,
  input  logic              rd_accept,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [15:0]       pass_cnt,
  output logic [CNT_W-1:0]  outstanding,
  output logic              all_checked,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);

  logic [ADDR_W-1:0] chk_addr;
  logic [DATA_W-1:0] expected;
  logic              ret;
  logic              spurious;

  assign expected    = DATA_W'(pat(32'(chk_addr), pass_cnt));
  assign ret         = rd_valid && (outstanding != '0);
  assign spurious    = rd_valid && (outstanding == '0);
  assign all_checked = (chk_addr == END_ADDR);

  // Outstanding count, compare pointer and sticky error capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      chk_addr    <= '0;
      error       <= 1'b0;
      err_addr    <= '0;
    end else begin
      if (clear) begin
        error    <= 1'b0;
        err_addr <= '0;
      end
      if (clear || reload) begin
        outstanding <= '0;
        chk_addr    <= START_ADDR;
      end else if (active) begin
        outstanding <= outstanding + CNT_W'(rd_accept) - CNT_W'(ret);
        if (ret) begin
          chk_addr <= chk_addr + ADDR_STEP;
          if (rd_data != expected) begin
            error <= 1'b1;
            if (!error) err_addr <= chk_addr;
          end
        end
        // Data with nothing in flight cannot be matched to an address.
        if (spurious) begin
          error <= 1'b1;
          if (!error) err_addr <= '1;
        end
      end
    end
  end

endmodule

// File: rtl/ddr3_test_sequencer.sv
// DDR3 MIG app-interface memory test: write pattern over a region, read it
// back through the checker, optionally looping with a new pattern per pass.
module ddr3_test_sequencer
  import ddr3_test_pkg::*;
#(
  parameter int                ADDR_W          = 28,
  parameter int                DATA_W          = 128,
  parameter logic [ADDR_W-1:0] START_ADDR      = 28'h0000000,
  parameter logic [ADDR_W-1:0] END_ADDR        = 28'h0010000,
  parameter logic [ADDR_W-1:0] ADDR_STEP       = 8,
  parameter int                MAX_OUTSTANDING = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_calib_done,
  input  logic              i_start,
  input  logic              i_continuous,
  output logic [ADDR_W-1:0] o_app_addr,
  output logic [2:0]        o_app_cmd,
  output logic              o_app_en,
  input  logic              i_app_rdy,
  output logic [DATA_W-1:0] o_app_wdf_data,
  output logic              o_app_wdf_wren,
  output logic              o_app_wdf_end,
  input  logic              i_app_wdf_rdy,
  input  logic [DATA_W-1:0] i_app_rd_data,
  input  logic              i_app_rd_data_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W-1:0] o_err_addr,
  output logic [15:0]       o_pass_cnt
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = END_ADDR - ADDR_STEP;

  state_t            state, state_d;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              cmd_done, dat_done;
  logic [CNT_W-1:0]  outstanding;
  logic              all_checked;
  logic              cmd_hs, dat_hs, retire, rd_accept;
  logic              load, clear, pass_inc;

  assign o_app_wdf_data = DATA_W'(pat(32'(wr_addr), o_pass_cnt));
  assign o_app_wdf_end  = o_app_wdf_wren;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next state, app strobes and datapath controls.
  always_comb begin
    state_d        = state;
    o_app_en       = 1'b0;
    o_app_cmd      = CMD_WRITE;
    o_app_addr     = wr_addr;
    o_app_wdf_wren = 1'b0;
    o_busy         = 1'b0;
    o_done         = 1'b0;
    cmd_hs         = 1'b0;
    dat_hs         = 1'b0;
    retire         = 1'b0;
    rd_accept      = 1'b0;
    load           = 1'b0;
    clear          = 1'b0;
    pass_inc       = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        o_done = (state == S_DONE);
        if (i_start) begin
          clear   = 1'b1;
          state_d = S_WAIT_CALIB;
        end
      end
      S_WAIT_CALIB: begin
        o_busy = 1'b1;
        if (i_calib_done) begin
          load    = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        o_busy         = 1'b1;
        o_app_en       = !cmd_done;
        o_app_wdf_wren = !dat_done;
        cmd_hs         = o_app_en && i_app_rdy;
        dat_hs         = o_app_wdf_wren && i_app_wdf_rdy;
        if (!i_calib_done) begin
          state_d = S_IDLE;
        end else if ((cmd_done || cmd_hs) && (dat_done || dat_hs)) begin
          retire = 1'b1;
          if (wr_addr == LAST_ADDR) state_d = S_READ;
        end
      end
      S_READ: begin
        o_busy     = 1'b1;
        o_app_cmd  = CMD_READ;
        o_app_addr = rd_addr;
        o_app_en   = (outstanding < CNT_W'(MAX_OUTSTANDING));
        rd_accept  = o_app_en && i_app_rdy;
        if (!i_calib_done)                       state_d = S_IDLE;
        else if (rd_accept && rd_addr == LAST_ADDR) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        if (!i_calib_done) begin
          state_d = S_IDLE;
        end else if (outstanding == '0 && all_checked) begin
          pass_inc = 1'b1;
          if (i_continuous) begin
            load    = 1'b1;
            state_d = S_WRITE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address pointers, per-beat handshake flags and pass counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_addr    <= '0;
      rd_addr    <= '0;
      cmd_done   <= 1'b0;
      dat_done   <= 1'b0;
      o_pass_cnt <= '0;
    end else begin
      if (clear)    o_pass_cnt <= '0;
      if (pass_inc) o_pass_cnt <= o_pass_cnt + 16'd1;
      if (load) begin
        wr_addr  <= START_ADDR;
        rd_addr  <= START_ADDR;
        cmd_done <= 1'b0;
        dat_done <= 1'b0;
      end else begin
        if (retire) begin
          wr_addr  <= wr_addr + ADDR_STEP;
          cmd_done <= 1'b0;
          dat_done <= 1'b0;
        end else begin
          if (cmd_hs) cmd_done <= 1'b1;
          if (dat_hs) dat_done <= 1'b1;
        end
        if (rd_accept) rd_addr <= rd_addr + ADDR_STEP;
      end
    end
  end

  ddr3_test_checker #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .START_ADDR (START_ADDR),
    .END_ADDR   (END_ADDR),
    .ADDR_STEP  (ADDR_STEP),
    .CNT_W      (CNT_W)
  ) u_checker (
    .clk         (i_clk),
    .rst         (i_rst),
    .clear       (clear),
    .reload      (load),
    .active      (state == S_READ || state == S_DRAIN),
    .rd_accept   (rd_accept),
    .rd_valid    (i_app_rd_data_valid),
    .rd_data     (i_app_rd_data),
    .pass_cnt    (o_pass_cnt),
    .outstanding (outstanding),
    .all_checked (all_checked),
    .error       (o_error),
    .err_addr    (o_err_addr)
  );

endmodule

// File: tb/tb_ddr3_test_sequencer.sv
// Directed bench for ddr3_test_sequencer with a small MIG behavioural model.
module tb_ddr3_test_sequencer;
  import ddr3_test_pkg::*;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          calib = 1'b0, start = 1'b0, cont = 1'b0;
  logic [AW-1:0] app_addr, err_addr;
  logic [2:0]    app_cmd;
  logic          app_en, app_rdy, wdf_wren, wdf_end, wdf_rdy, rd_valid;
  logic [DW-1:0] wdf_data, rd_data;
  logic          busy, done, error;
  logic [15:0]   pass_cnt;

  always #5 clk = ~clk;

  ddr3_test_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .START_ADDR(28'h0), .END_ADDR(28'h40),
    .ADDR_STEP(28'd8), .MAX_OUTSTANDING(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_calib_done(calib), .i_start(start),
    .i_continuous(cont), .o_app_addr(app_addr), .o_app_cmd(app_cmd),
    .o_app_en(app_en), .i_app_rdy(app_rdy), .o_app_wdf_data(wdf_data),
    .o_app_wdf_wren(wdf_wren), .o_app_wdf_end(wdf_end), .i_app_wdf_rdy(wdf_rdy),
    .i_app_rd_data(rd_data), .i_app_rd_data_valid(rd_valid), .o_busy(busy),
    .o_done(done), .o_error(error), .o_err_addr(err_addr), .o_pass_cnt(pass_cnt)
  );

  // Model controls, written only by the stimulus block.
  int            rdy_mode = 0;
  int            rd_lat = 2;
  logic [AW-1:0] inj_a = '1, inj_b = '1;
  logic          log_clr = 1'b0;

  // Model state, written only by the model block.
  logic [DW-1:0] mem [8];
  logic [AW-1:0] wr_log [16];
  int            wr_n, wd_n, rd_acc, rd_ret, max_fl, cyc;
  logic [AW-1:0] wcmd_q [$];
  logic [DW-1:0] wdat_q [$];
  logic [AW-1:0] rq_addr [$];
  int            rq_due [$];

  int errors = 0;
  int checks = 0;

  // MIG model: drives ready/return at the falling edge for the next rising edge.
  initial begin : mig_model
    logic [7:0]    rdy_pat;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    rdy_pat = 8'b1001_0011;
    cyc = 0; wr_n = 0; wd_n = 0; rd_acc = 0; rd_ret = 0; max_fl = 0;
    app_rdy = 1'b0; wdf_rdy = 1'b0; rd_valid = 1'b0; rd_data = '0;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (log_clr) begin
        wr_n = 0; wd_n = 0; rd_acc = 0; rd_ret = 0; max_fl = 0;
        wcmd_q.delete(); wdat_q.delete(); rq_addr.delete(); rq_due.delete();
        app_rdy = 1'b0; wdf_rdy = 1'b0; rd_valid = 1'b0; rd_data = '0;
      end else begin
        case (rdy_mode)
          1:       begin app_rdy = rdy_pat[cyc % 8];       wdf_rdy = rdy_pat[(cyc + 5) % 8]; end
          2:       begin app_rdy = rdy_pat[(cyc + 5) % 8]; wdf_rdy = rdy_pat[cyc % 8];       end
          default: begin app_rdy = 1'b1;                   wdf_rdy = 1'b1;                   end
        endcase
        rd_valid = 1'b0;
        rd_data  = '0;
        if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
          a = rq_addr.pop_front();
          void'(rq_due.pop_front());
          d = mem[a[5:3]];
          if (a == inj_a || a == inj_b) d[5] = ~d[5];
          rd_valid = 1'b1;
          rd_data  = d;
          rd_ret++;
        end
        if (app_en && app_rdy) begin
          if (app_cmd == CMD_WRITE) begin
            wcmd_q.push_back(app_addr);
            if (wr_n < 16) wr_log[wr_n] = app_addr;
            wr_n++;
          end else begin
            rq_addr.push_back(app_addr);
            rq_due.push_back(cyc + rd_lat);
            rd_acc++;
          end
        end
        if (wdf_wren && wdf_rdy) begin
          wdat_q.push_back(wdf_data);
          wd_n++;
        end
        if (wcmd_q.size() > 0 && wdat_q.size() > 0) begin
          a = wcmd_q.pop_front();
          mem[a[5:3]] = wdat_q.pop_front();
        end
        if (rd_acc - rd_ret > max_fl) max_fl = rd_acc - rd_ret;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    @(negedge clk); log_clr = 1'b1;
    @(negedge clk);
    @(negedge clk); log_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n = 0;
    while (!done && n < lim) begin @(negedge clk); n++; end
    check({tag, "_done"}, done, 1'b1);
  endtask

  // Writes went to 0x00..0x38 once each, in order, with the pass-0 pattern.
  task automatic check_writes(input string tag);
    logic ok;
    ok = (wr_n == 8) && (wd_n == 8);
    for (int i = 0; i < 8; i++) begin
      if (wr_log[i] != AW'(i * 8)) ok = 1'b0;
      if (mem[i] != pat(32'(i * 8), 16'h0)) ok = 1'b0;
    end
    check({tag, "_writes"}, ok, 1'b1);
  endtask

  initial begin : stim
    int n;
    // Reset state
    #12;
    check("rst_app_en", app_en, 1'b0);
    check("rst_wren", wdf_wren, 1'b0);
    check("rst_wdf_end", wdf_end, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_err_addr", err_addr, 28'h0);
    check("rst_pass_cnt", pass_cnt, 16'h0);
    check("rst_app_addr", app_addr, 28'h0);
    check("rst_wdf_data", wdf_data, 128'h0);
    @(negedge clk); rst = 1'b0; calib = 1'b1;

    // Clean single pass
    clear_log(); pulse_start();
    check("clean_busy", busy, 1'b1);
    wait_done("clean", 400);
    check("clean_error", error, 1'b0);
    check("clean_pass", pass_cnt, 16'd1);
    check("clean_busy_end", busy, 1'b0);
    check("clean_beat08", mem[1], {8{16'h0001}});
    check("clean_reads", rd_ret, 8);
    check_writes("clean");

    // Data ready lags command ready, then leads it
    rdy_mode = 1;
    clear_log(); pulse_start(); wait_done("lag", 800);
    check("lag_error", error, 1'b0);
    check("lag_reads", rd_ret, 8);
    check_writes("lag");
    rdy_mode = 2;
    clear_log(); pulse_start(); wait_done("lead", 800);
    check("lead_error", error, 1'b0);
    check_writes("lead");
    rdy_mode = 0;

    // Injected errors: first error address is kept
    inj_a = 28'h20;
    clear_log(); pulse_start(); wait_done("inj1", 400);
    check("inj1_error", error, 1'b1);
    check("inj1_err_addr", err_addr, 28'h20);
    inj_b = 28'h30;
    clear_log(); pulse_start();
    check("inj2_cleared", error, 1'b0);
    wait_done("inj2", 400);
    check("inj2_error", error, 1'b1);
    check("inj2_err_addr", err_addr, 28'h20);
    inj_a = '1; inj_b = '1;

    // Outstanding limit with long read latency
    rd_lat = 20;
    clear_log(); pulse_start(); wait_done("lim", 1000);
    check("lim_max_inflight", max_fl, 4);
    check("lim_reads", rd_ret, 8);
    check("lim_error", error, 1'b0);
    rd_lat = 2;

    // Continuous mode: drop the loop request during the third pass
    cont = 1'b1;
    clear_log(); pulse_start();
    n = 0;
    while (pass_cnt != 16'd2 && n < 600) begin @(negedge clk); n++; end
    check("cont_reach2", pass_cnt, 16'd2);
    check("cont_not_done", done, 1'b0);
    cont = 1'b0;
    wait_done("cont", 600);
    check("cont_pass", pass_cnt, 16'd3);
    check("cont_beat08", mem[1], {8{16'h0003}});
    check("cont_error", error, 1'b0);

    // Calibration loss mid-READ
    clear_log(); pulse_start();
    n = 0;
    while (!(app_en && app_cmd == CMD_READ) && n < 200) begin @(negedge clk); n++; end
    check("abort_in_read", app_cmd, CMD_READ);
    calib = 1'b0;
    @(negedge clk);
    check("abort_app_en", app_en, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    calib = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_idle_error", error, 1'b0);
    check("abort_idle_done", done, 1'b0);

    // Asynchronous reset mid-WRITE
    clear_log(); pulse_start();
    n = 0;
    while (!(wdf_wren && app_addr == 28'h10) && n < 200) begin @(negedge clk); n++; end
    check("rstw_in_write", app_addr, 28'h10);
    #2 rst = 1'b1;
    #1;
    check("rstw_app_en", app_en, 1'b0);
    check("rstw_wren", wdf_wren, 1'b0);
    check("rstw_busy", busy, 1'b0);
    check("rstw_app_addr", app_addr, 28'h0);
    check("rstw_wdf_data", wdf_data, 128'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
